wrr_prio_table: RTL and testbench



---
 rtl/wrr_pkg.sv | 33 +++
 rtl/wrr_prio_table_if.sv | 31 +++
 rtl/wrr_prio_entry.sv | 85 ++++++++
 rtl/wrr_prio_table.sv | 97 +++++++++
 tb/tb_wrr_prio_table.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_pkg.sv
// ---------------------------------------------------------------------------
// wrr_pkg
// Shared types and constants for the weighted round-robin arbiter blocks.
// The priority-update channel carries a 5-bit requester id and a PRIO_W-bit
// weight. Every block that touches weights or ids imports this package, so
// the widths only live here.
// ---------------------------------------------------------------------------
package wrr_pkg;

  // Width of one requester weight. A weight of 0 disables the requester.
  localparam int PRIO_W = 4;

  // Width of the requester index on the update channel.
  localparam int ID_W = 5;

  // Largest requester count the 5-bit id can address.
  localparam int MAX_REQ = 32;

  typedef logic [PRIO_W-1:0] prio_t;
  typedef logic [ID_W-1:0]   prio_id_t;

  // True when an id addresses a requester that actually exists.
  // The id is widened before comparing so that nReq = 32 (one past the
  // largest 5-bit value) still compares correctly.
  function automatic logic id_in_range(input prio_id_t id, input int nReq);
    logic [31:0] idWide;
    logic [31:0] nReqWide;
    idWide   = 32'(id);
    nReqWide = 32'(nReq);
    return idWide < nReqWide;
  endfunction

endpackage

// File: rtl/wrr_prio_table_if.sv
// ---------------------------------------------------------------------------
// wrr_prio_table_if
// Priority-update channel between the configuration source (master) and the
// priority table (slave). There is no handshake back to the source: an
// update is taken on every clock in which prio_upt is high.
//   prio_upt : update strobe, one update per cycle while high
//   prio_id  : target requester index
//   prio     : new weight for that requester (0 = disabled)
// ---------------------------------------------------------------------------
interface wrr_prio_table_if;
  import wrr_pkg::*;

  logic     prio_upt;
  prio_id_t prio_id;
  prio_t    prio;

  // The update source drives the channel.
  modport master (
    output prio_upt,
    output prio_id,
    output prio
  );

  // The priority table only ever listens.
  modport slave (
    input prio_upt,
    input prio_id,
    input prio
  );

endinterface

// File: rtl/wrr_prio_entry.sv
// ---------------------------------------------------------------------------
// wrr_prio_entry
// One requester's slot in the priority table. It keeps three pieces of
// state:
//   shadow : the most recently written weight, not yet visible to the arbiter
//   pend   : shadow holds a value that has not been committed yet
//   active : the weight the grant engine currently uses
// Writes land in shadow and raise pend. On a round boundary a pending
// shadow value is copied into active and pend drops. A write in the same
// cycle as the round boundary is folded straight into that commit.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst         : synchronous active-high reset, beats everything else
//   wr_en_i     : this entry is the target of a legal update this cycle
//   wr_data_i   : weight carried by that update
//   round_end_i : arbitration round boundary, commit pending value
//   active_o    : committed weight (register)
//   pend_o      : pending flag (register)
//   pend_next_o : value pend takes at the next edge, for the registered
//                 pending summary in the top level
// ---------------------------------------------------------------------------
module wrr_prio_entry
  import wrr_pkg::*;
#(
  parameter prio_t DEFAULT_PRIO = prio_t'(1)
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en_i,
  input  prio_t wr_data_i,
  input  logic  round_end_i,
  output prio_t active_o,
  output logic  pend_o,
  output logic  pend_next_o
);

  prio_t shadow_q;
  prio_t shadow_d;
  prio_t active_q;
  prio_t active_d;
  logic  pend_q;
  logic  pend_d;

  // Next-state for the entry. The write is applied first and the commit
  // then looks at the post-write values, which is what makes an update in
  // the round_end cycle land in active right away and leave pend clear.
  // The commit is gated by pend, so an entry nobody wrote keeps its active
  // weight even when its shadow happens to differ.
  always_comb begin
    shadow_d = shadow_q;
    pend_d   = pend_q;
    active_d = active_q;

    if (wr_en_i) begin
      shadow_d = wr_data_i;
      pend_d   = 1'b1;
    end

    if (round_end_i && pend_d) begin
      active_d = shadow_d;
      pend_d   = 1'b0;
    end
  end

  // State registers. Reset discards any uncommitted write: shadow returns
  // to the default weight together with active, so nothing stale can be
  // committed later.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= DEFAULT_PRIO;
      active_q <= DEFAULT_PRIO;
      pend_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
    end
  end

  assign active_o    = active_q;
  assign pend_o      = pend_q;
  assign pend_next_o = rst ? 1'b0 : pend_d;

endmodule

// File: rtl/wrr_prio_table.sv
// ---------------------------------------------------------------------------
// wrr_prio_table
// Receiving end of the priority-update channel for the weighted round-robin
// arbiter. Weight updates are parked in a per-requester shadow slot and only
// become visible to the grant engine when it signals the end of a round, so
// the weights never change while a round's credits are being spent.
//
// Ports
//   clk           : clock
//   rst           : synchronous active-high reset
//   upd_if        : update channel (prio_upt / prio_id / prio), slave side
//   round_end_i   : one-cycle pulse from the grant engine at a round boundary
//   prio_table_o  : committed weights, entry i at [i*PRIO_W +: PRIO_W]
//   pending_any_o : at least one written weight is still uncommitted
//   commit_o      : pulse, the committed table changed in this cycle
//   upd_err_o     : pulse, an update was dropped because its id was too big
// ---------------------------------------------------------------------------
module wrr_prio_table
  import wrr_pkg::*;
#(
  parameter int    N_REQ        = 32,
  parameter prio_t DEFAULT_PRIO = prio_t'(1)
) (
  input  logic                    clk,
  input  logic                    rst,
  wrr_prio_table_if.slave         upd_if,
  input  logic                    round_end_i,
  output logic [N_REQ*PRIO_W-1:0] prio_table_o,
  output logic                    pending_any_o,
  output logic                    commit_o,
  output logic                    upd_err_o
);

  logic             idLegal;
  logic [N_REQ-1:0] wrEn;
  logic [N_REQ-1:0] pendVec;
  logic [N_REQ-1:0] pendNextVec;
  logic             commitHit;

  logic commit_q;
  logic updErr_q;
  logic pendingAny_q;

  // An update only reaches the table when its id names a real requester.
  // Out-of-range ids are swallowed here and reported through upd_err.
  assign idLegal = id_in_range(upd_if.prio_id, N_REQ);

  // One slot per requester. Each slot gets a private write enable from the
  // id decode; all slots see the same write data and round boundary. The
  // committed weights are packed side by side for the grant engine.
  for (genvar i = 0; i < N_REQ; i++) begin : gEntry
    prio_t activeW;

    assign wrEn[i] = upd_if.prio_upt && idLegal &&
                     (upd_if.prio_id == prio_id_t'(i));

    wrr_prio_entry #(
      .DEFAULT_PRIO (DEFAULT_PRIO)
    ) uEntry (
      .clk         (clk),
      .rst         (rst),
      .wr_en_i     (wrEn[i]),
      .wr_data_i   (upd_if.prio),
      .round_end_i (round_end_i),
      .active_o    (activeW),
      .pend_o      (pendVec[i]),
      .pend_next_o (pendNextVec[i])
    );

    assign prio_table_o[i*PRIO_W +: PRIO_W] = activeW;
  end

  // The table changes on a round boundary only if some slot has something
  // to commit, either from an earlier write or from a write arriving in
  // this very cycle. A rewrite with the current weight still counts.
  assign commitHit = round_end_i && (|(pendVec | wrEn));

  // Status flags. All three are registered so no input reaches an output
  // combinationally. The pending summary is built from the slots' next-state
  // pend bits so it lines up with the slots themselves.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_q     <= 1'b0;
      updErr_q     <= 1'b0;
      pendingAny_q <= 1'b0;
    end else begin
      commit_q     <= commitHit;
      updErr_q     <= upd_if.prio_upt && !idLegal;
      pendingAny_q <= |pendNextVec;
    end
  end

  assign commit_o      = commit_q;
  assign upd_err_o     = updErr_q;
  assign pending_any_o = pendingAny_q;

endmodule

// File: tb/tb_wrr_prio_table.sv
// ---------------------------------------------------------------------------
// tb_wrr_prio_table
// Self-checking bench for wrr_prio_table with 20 requesters, so that ids
// 20..31 on the 5-bit channel are out of range. A table-level model tracks
// shadow weights, pending flags and committed weights per requester and
// predicts every output after each clock.
// ---------------------------------------------------------------------------
module tb_wrr_prio_table;
  import wrr_pkg::*;

  localparam int N = 20;

  logic                clk = 1'b0;
  logic                rst;
  logic                roundEnd;
  logic [N*PRIO_W-1:0] prioTable;
  logic                pendingAny;
  logic                commit;
  logic                updErr;

  int checkCount = 0;
  int errorCount = 0;

  // Model state, indexed by requester.
  int shadowM [N];
  int activeM [N];
  bit pendM   [N];
  bit commitM;
  bit updErrM;

  wrr_prio_table_if updIf ();

  wrr_prio_table #(
    .N_REQ        (N),
    .DEFAULT_PRIO (prio_t'(1))
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .upd_if        (updIf.slave),
    .round_end_i   (roundEnd),
    .prio_table_o  (prioTable),
    .pending_any_o (pendingAny),
    .commit_o      (commit),
    .upd_err_o     (updErr)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the model, straight from the behavioural rules: reset
  // wins; otherwise a legal update overwrites the shadow and marks it
  // pending, then a round boundary publishes everything pending.
  task automatic modelStep(input bit upt, input int id, input int p,
                           input bit re, input bit rs);
    bit any;
    if (rs) begin
      foreach (activeM[i]) begin
        activeM[i] = 1;
        shadowM[i] = 1;
        pendM[i]   = 1'b0;
      end
      commitM = 1'b0;
      updErrM = 1'b0;
      return;
    end
    updErrM = upt && (id >= N);
    if (upt && id < N) begin
      shadowM[id] = p;
      pendM[id]   = 1'b1;
    end
    any = 1'b0;
    if (re) begin
      foreach (activeM[i]) begin
        if (pendM[i]) begin
          activeM[i] = shadowM[i];
          pendM[i]   = 1'b0;
          any        = 1'b1;
        end
      end
    end
    commitM = any;
  endtask

  function automatic logic [N*PRIO_W-1:0] modelTable();
    logic [N*PRIO_W-1:0] t;
    foreach (activeM[i]) t[i*PRIO_W +: PRIO_W] = PRIO_W'(activeM[i]);
    return t;
  endfunction

  function automatic bit modelPendingAny();
    bit any;
    any = 1'b0;
    foreach (pendM[i]) any |= pendM[i];
    return any;
  endfunction

  function automatic logic [PRIO_W-1:0] dutEntry(input int i);
    return prioTable[i*PRIO_W +: PRIO_W];
  endfunction

  // Drive one cycle of inputs, advance the model over the same edge, then
  // compare all outputs 1 unit after the edge and return the bus to idle.
  task automatic applyStimulus(input bit upt, input int id, input int p,
                               input bit re, input bit rs);
    rst            = rs;
    roundEnd       = re;
    updIf.prio_upt = upt;
    updIf.prio_id  = prio_id_t'(id);
    updIf.prio     = prio_t'(p);
    @(posedge clk);
    modelStep(upt, id, p, re, rs);
    #1;
    checkOutput("prio_table", 128'(prioTable), 128'(modelTable()));
    checkOutput("pending_any", 128'(pendingAny), 128'(modelPendingAny()));
    checkOutput("commit", 128'(commit), 128'(commitM));
    checkOutput("upd_err", 128'(updErr), 128'(updErrM));
    rst            = 1'b0;
    roundEnd       = 1'b0;
    updIf.prio_upt = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    roundEnd       = 1'b0;
    updIf.prio_upt = 1'b0;
    updIf.prio_id  = '0;
    updIf.prio     = '0;

    // Reset values.
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    idleCycles(2);
    checkOutput("reset_table", 128'(prioTable), 128'({N{4'd1}}));
    checkOutput("reset_pending", 128'(pendingAny), 128'(0));
    checkOutput("reset_commit", 128'(commit), 128'(0));

    // Update held back until the round boundary.
    applyStimulus(1'b1, 3, 9, 1'b0, 1'b0);
    idleCycles(10);
    checkOutput("held_entry3", 128'(dutEntry(3)), 128'(1));
    checkOutput("held_pending", 128'(pendingAny), 128'(1));
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("commit_entry3", 128'(dutEntry(3)), 128'(9));
    checkOutput("commit_pulse", 128'(commit), 128'(1));
    checkOutput("commit_pending", 128'(pendingAny), 128'(0));
    idleCycles(1);
    checkOutput("commit_once", 128'(commit), 128'(0));

    // Last write wins.
    applyStimulus(1'b1, 7, 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 7, 12, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("lastwrite_entry7", 128'(dutEntry(7)), 128'(12));
    checkOutput("lastwrite_entry6", 128'(dutEntry(6)), 128'(1));

    // Update in the same cycle as the round boundary.
    applyStimulus(1'b1, 0, 15, 1'b1, 1'b0);
    checkOutput("wt_entry0", 128'(dutEntry(0)), 128'(15));
    checkOutput("wt_commit", 128'(commit), 128'(1));
    checkOutput("wt_pending", 128'(pendingAny), 128'(0));

    // Rewriting the current weight still commits.
    applyStimulus(1'b1, 0, 15, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("same_commit", 128'(commit), 128'(1));

    // Round boundary with nothing pending.
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("empty_commit", 128'(commit), 128'(0));

    // Out-of-range id is dropped and flagged.
    applyStimulus(1'b1, 25, 5, 1'b0, 1'b0);
    checkOutput("illegal_err", 128'(updErr), 128'(1));
    checkOutput("illegal_pending", 128'(pendingAny), 128'(0));
    idleCycles(1);
    checkOutput("illegal_err_once", 128'(updErr), 128'(0));
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("illegal_commit", 128'(commit), 128'(0));
    applyStimulus(1'b1, N, 4, 1'b0, 1'b0);
    checkOutput("boundary_err", 128'(updErr), 128'(1));

    // round_end held high: second cycle commits only the newer write.
    applyStimulus(1'b1, 5, 3, 1'b0, 1'b0);
    applyStimulus(1'b1, 6, 8, 1'b1, 1'b0);
    applyStimulus(1'b1, 5, 11, 1'b1, 1'b0);
    checkOutput("held_re_entry5", 128'(dutEntry(5)), 128'(11));
    checkOutput("held_re_commit", 128'(commit), 128'(1));
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    checkOutput("held_re_idle", 128'(commit), 128'(0));

    // Reset together with round_end discards the pending write.
    applyStimulus(1'b1, N-1, 6, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    checkOutput("rst_entry_last", 128'(dutEntry(N-1)), 128'(1));
    checkOutput("rst_commit", 128'(commit), 128'(0));
    checkOutput("rst_pending", 128'(pendingAny), 128'(0));
    checkOutput("rst_table", 128'(prioTable), 128'({N{4'd1}}));

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      applyStimulus($urandom_range(0, 99) < 60,
                    int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 15)),
                    $urandom_range(0, 99) < 15,
                    $urandom_range(0, 199) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
